// File: rtl/console_uart_tx_pkg.sv
// Shared constants for the console UART transmitter: default sizes and the
// line-state encoding used by the serialiser FSM.
package console_uart_tx_pkg;

    localparam int XLEN_DEFAULT         = 32;
    localparam int CLKS_PER_BIT_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT   = 8;
    localparam int BYTE_W               = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/console_uart_tx_if.sv
// Console MMIO write port as seen between the core top level (master) and
// the UART transmitter (slave).
//
// Handshake: console_we is a one-cycle strobe with no ready. Every rising
// edge with console_we = 1 is exactly one byte push of console_wdata[7:0];
// a push the queue cannot hold is dropped and reported via the sticky
// overflow flag.
interface console_uart_tx_if #(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0] console_wdata;
    logic            console_we;

    modport master (output console_wdata, output console_we);
    modport slave  (input  console_wdata, input  console_we);

endinterface

// File: rtl/console_uart_tx_fifo.sv
// Synchronous first-word-fall-through byte queue. Full/empty come from the
// occupancy count, so the pointers need no extra wrap bit.
module console_uart_tx_fifo
    import console_uart_tx_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/console_uart_tx.sv
// Console write-port consumer: queues the low byte of each console write and
// shifts it out as 8N1, LSB first, on a registered UART line.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    console_uart_tx_if.slave            con,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output uart_state_e                 state_dbg
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);

    uart_state_e         state_q,   state_d;
    logic [TW-1:0]       timer_q,   timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]   shift_q,   shift_d;
    logic                tx_q,      tx_d;
    logic                overflow_q, overflow_d;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [BYTE_W-1:0]   fifo_rdata;
    logic                timer_done;
    logic                unused_upper;

    assign unused_upper = ^con.console_wdata[XLEN-1:BYTE_W];

    console_uart_tx_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (con.console_we),
        .pop   (fifo_pop),
        .wdata (con.console_wdata[BYTE_W-1:0]),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign timer_done = (timer_q == '0);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    timer_d  = TIMER_RELOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (timer_done) begin
                    timer_d   = TIMER_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_DATA: begin
                if (timer_done) begin
                    timer_d = TIMER_RELOAD;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_STOP: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The line level is a function of where the FSM is headed, so tx
        // changes on exactly the edge that starts each bit.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase

        overflow_d = overflow_q | (con.console_we & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: frame table, corner-case sequences and random
// pushes against a cycle-timeline model of the queue and line.
module tb_console_uart_tx;
    import console_uart_tx_pkg::*;

    localparam int XLEN  = 32;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [31:0] wdata;
        logic [9:0]  exp_line;   // bit i = i-th line bit of the frame
        int          exp_lat;    // edges from raising console_we to tx low
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            tx, busy, overflow;
    logic [CW-1:0]   fifo_count;
    uart_state_e     state_dbg;

    console_uart_tx_if #(.XLEN(XLEN)) con ();

    console_uart_tx #(
        .XLEN         (XLEN),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .con        (con),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .state_dbg  (state_dbg)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
        $fatal(1);
    end

    // ---------------- scoreboard / model state ----------------
    int total = 0;
    int bad   = 0;

    logic [7:0] m_q[$];      // model queue contents
    logic [7:0] exp_q[$];    // bytes expected on the line
    logic [7:0] rx_q[$];     // bytes decoded from the line
    int         m_now = 0;
    int         m_next_pop = 0;
    int         m_start = -100000;
    logic [7:0] m_byte = 8'h00;
    bit         m_ovf = 1'b0;
    int         rx_pos = -1;
    logic [7:0] rx_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit model_in_frame();
        int off;
        off = m_now - m_start;
        return (off >= 0) && (off < FRAME);
    endfunction

    // Line level from the frame layout: start 0, 8 data bits LSB first, stop 1.
    function automatic logic model_tx();
        int b;
        if (!model_in_frame()) return 1'b1;
        b = (m_now - m_start) / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_byte[b-1];
    endfunction

    // One rising edge of the model: the head byte may leave once the previous
    // frame plus one idle cycle is over; a push is refused only when full and
    // nothing leaves.
    task automatic model_edge(input logic we, input logic [31:0] wd);
        bit full, pop;
        m_now++;
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() > 0) && (m_now >= m_next_pop);
        if (pop) begin
            m_byte     = m_q.pop_front();
            m_start    = m_now;
            m_next_pop = m_now + FRAME + 1;
        end
        if (we) begin
            if (!full || pop) begin
                m_q.push_back(wd[7:0]);
                exp_q.push_back(wd[7:0]);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        rx_q.delete();
        m_start    = -100000;
        m_next_pop = 0;
        m_ovf      = 1'b0;
        rx_pos     = -1;
    endtask

    // Mid-bit sampling receiver, independent of the model.
    task automatic rx_sample();
        if (rx_pos < 0) begin
            if (tx === 1'b0) rx_pos = 0;
        end else begin
            rx_pos++;
        end
        if (rx_pos >= CPB && rx_pos < 9 * CPB && (rx_pos % CPB) == CPB / 2)
            rx_byte[rx_pos / CPB - 1] = tx;
        if (rx_pos == 9 * CPB + CPB / 2) begin
            rx_q.push_back(rx_byte);
            rx_pos = -1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic we, input logic [31:0] wd);
        con.console_we    = we;
        con.console_wdata = wd;
        @(posedge clk);
        model_edge(we, wd);
        @(negedge clk);
        check("tx",       tx,         model_tx());
        check("busy",     busy,       model_in_frame() || (m_q.size() != 0));
        check("overflow", overflow,   m_ovf);
        check("count",    fifo_count, m_q.size());
        rx_sample();
    endtask

    task automatic do_reset();
        con.console_we    = 1'b0;
        con.console_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1'b0, '0);
            n++;
        end
        check("drain_done", busy, 1'b0);
    endtask

    task automatic compare_sb(input string name);
        int n;
        check({name, "_nbytes"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({name, "_byte"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    // ---------------- test ----------------
    vec_t vecs[5];

    initial begin
        int          lat;
        logic [9:0]  got_line;
        bit          glitch;
        int          n;
        logic        tx40, tx41, busy80, busy81;

        vecs[0] = '{32'h0000_0041, 10'b10_1000_0010, 2};
        vecs[1] = '{32'hDEAD_BE55, 10'b10_1010_1010, 2};
        vecs[2] = '{32'h0000_00FF, 10'b11_1111_1110, 2};
        vecs[3] = '{32'hFFFF_FF00, 10'b10_0000_0000, 2};
        vecs[4] = '{32'h1234_5680, 10'b11_0000_0000, 2};

        con.console_we    = 1'b0;
        con.console_wdata = '0;

        // Reset state
        do_reset();
        check("rst_tx",       tx,         1'b1);
        check("rst_busy",     busy,       1'b0);
        check("rst_overflow", overflow,   1'b0);
        check("rst_count",    fifo_count, 0);

        // Single-frame table
        for (int v = 0; v < 5; v++) begin
            step(1'b1, vecs[v].wdata);
            lat = 1;
            while (tx === 1'b1 && lat < 10) begin
                step(1'b0, '0);
                lat++;
            end
            check("frame_latency", lat, vecs[v].exp_lat);
            glitch   = 1'b0;
            got_line = '0;
            for (int i = 0; i < FRAME; i++) begin
                if (i > 0) step(1'b0, '0);
                if (i % CPB == 0) got_line[i / CPB] = tx;
                else if (tx !== got_line[i / CPB]) glitch = 1'b1;
            end
            check("frame_line",   got_line, vecs[v].exp_line);
            check("frame_stable", glitch,   1'b0);
            step(1'b0, '0);
            check("frame_busy_end", busy, 1'b0);
        end
        compare_sb("table");

        // Reset in the middle of a frame with bytes still queued
        step(1'b1, 32'h11);
        step(1'b1, 32'h22);
        step(1'b1, 32'h33);
        repeat (10) step(1'b0, '0);
        check("pre_reset_tx_low", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_tx",    tx,         1'b1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy",  busy,       1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (6) step(1'b0, '0);

        // Ten back-to-back pushes: nine fit, the tenth overflows
        for (int i = 0; i < 10; i++) step(1'b1, 32'h30 + i);
        check("ovf_flag",  overflow,   1'b1);
        check("ovf_count", fifo_count, 8);
        step(1'b0, '0);
        wait_idle(600);
        check("ovf_sticky", overflow,   1'b1);
        check("ovf_nbytes", rx_q.size(), 9);
        if (rx_q.size() == 9) begin
            check("ovf_first", rx_q[0], 8'h30);
            check("ovf_last",  rx_q[8], 8'h38);
        end
        compare_sb("ovf");

        // Push into a full queue on the very cycle the FSM pops
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 32'h60 + i);
        n = 0;
        while (state_dbg != ST_IDLE && n < 100) begin
            step(1'b0, '0);
            n++;
        end
        check("simul_reached_idle", (state_dbg == ST_IDLE), 1'b1);
        check("simul_pre_count",    fifo_count, 8);
        step(1'b1, 32'h69);
        check("simul_count",    fifo_count, 8);
        check("simul_overflow", overflow,   1'b0);
        wait_idle(600);
        check("simul_nbytes", rx_q.size(), 10);
        compare_sb("simul");

        // Two queued bytes: one idle cycle between frames, 81 cycles overall
        do_reset();
        step(1'b1, 32'hA5);
        step(1'b1, 32'h5A);
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            step(1'b0, '0);
            n++;
        end
        check("b2b_start_found", tx, 1'b0);
        tx40 = 1'b0; tx41 = 1'b1; busy80 = 1'b0; busy81 = 1'b1;
        for (int k = 1; k <= 81; k++) begin
            step(1'b0, '0);
            if (k == 40) tx40   = tx;
            if (k == 41) tx41   = tx;
            if (k == 80) busy80 = busy;
            if (k == 81) busy81 = busy;
        end
        check("b2b_idle_gap",    tx40,   1'b1);
        check("b2b_second_start", tx41,  1'b0);
        check("b2b_busy_last",   busy80, 1'b1);
        check("b2b_busy_end",    busy81, 1'b0);
        compare_sb("b2b");

        // Randomised pushes, including overflow pressure
        do_reset();
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 5) == 0), $urandom);
        wait_idle(800);
        compare_sb("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
Consumer end of the processor's console MMIO write port.
- Accepts the single-cycle console write strobe and its data word from the core top level.
- Queues the low byte of each write in a small FIFO.
- Serialises queued bytes onto a UART line as 8N1, LSB first.
- Sits beside the core top level, between its console outputs and the board/testbench serial pin.

Parameters:
XLEN, 32, width of the console data word; only bits [7:0] are transmitted.
CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 2.
FIFO_DEPTH, 8, byte entries in the queue; must be a power of two, >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
console_wdata  input  XLEN  console write data; sampled only when console_we = 1.
console_we  input  1  one-cycle write strobe; each high cycle is one byte push.
tx  output  1  UART serial line; idle high.
busy  output  1  high while the FIFO is non-empty or a frame is in flight.
overflow  output  1  sticky flag: a push was dropped because the FIFO was full.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte currently shifting.

Behaviour:
Reset (reset = 0, asynchronous assert, synchronous deassert by upstream):
- tx = 1, busy = 0, overflow = 0, fifo_count = 0, FSM = IDLE.
- FIFO pointers and bit counters cleared.
- Reset mid-frame aborts the frame immediately: tx returns to 1 with no stop-bit completion, and queued bytes are discarded.

Push:
- On a rising edge with console_we = 1, console_wdata[7:0] is written to the FIFO tail.
- fifo_count increments at that edge.
- Upper bits [XLEN-1:8] are ignored.
- Push while full and no pop in the same cycle: byte dropped, overflow set to 1 and held until reset, fifo_count unchanged.
- Push and pop in the same cycle, including when full: both take effect, fifo_count unchanged, no overflow.

FSM states: IDLE, START, DATA, STOP.
- IDLE: tx = 1. If the FIFO is non-empty, pop the head byte into an 8-bit shift register, load the bit timer with CLKS_PER_BIT-1, go to START.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7 completes, go to STOP.
- STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back: IDLE with a non-empty FIFO pops in its first cycle, so consecutive frames have exactly 1 idle cycle between the stop bit and the next start bit.

Timing:
- Bit timer counts down from CLKS_PER_BIT-1; the phase advances when the timer = 0.
- Latency: console_we high at edge N into an empty, idle block → tx falls at edge N+2 (N+1 stores the byte, N+2 pops and enters START).
- One frame is 10*CLKS_PER_BIT cycles.

Outputs:
- busy = (FSM != IDLE) || (fifo_count != 0).
- tx is registered and glitch-free.

Width rules:
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Full/empty are derived from fifo_count; no extra pointer bit is needed.

Decomposition:
- The UART state encodings (IDLE/START/DATA/STOP) and the default CLKS_PER_BIT belong in the shared constants.vh include, alongside the existing XLEN definitions.
- One sub-module is natural: console_fifo, a synchronous FIFO.
  - Parameters: WIDTH = 8, DEPTH.
  - Ports: push/pop/wdata/rdata/count/full/empty.
  - Same clk and asynchronous active-low reset.
  - First-word-fall-through: rdata is valid whenever empty = 0.
- console_uart_tx keeps the FSM, bit timer, shift register and overflow flag.

Test Plan:
1. Reset low for 3 cycles, then high → tx = 1, busy = 0, overflow = 0, fifo_count = 0. Assert reset mid-frame → tx = 1 on the same cycle, fifo_count = 0.
2. CLKS_PER_BIT = 4; single push of 0x0000_0041 → tx falls 2 cycles later. Line reads 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles wide (40 cycles), then busy = 0.
3. Push 0xDEAD_BE55 → only 0x55 is sent: data bits 1,0,1,0,1,0,1,0, LSB first.
4. FIFO_DEPTH = 8; 10 consecutive pushes of 0x30..0x39 starting from idle. First byte pops at cycle 2, so 9 bytes fit. 0x39 is dropped, overflow = 1 (sticky), and the line carries 0x30..0x38 in order.
5. FIFO full and the FSM popping in the same cycle as console_we = 1 → push accepted, fifo_count stays 8, overflow stays 0.
6. Two queued bytes 0xA5, 0x5A → exactly 1 idle-high cycle between the first stop bit and the second start bit; total 81 cycles from the first start edge to the final stop-bit end.
